// File: rtl/vector_element_sequencer.sv
// Vector element sequencer: walks one decoded vector-vector integer op element by
// element (vstart..vl-1) and drives the register file's next-state inputs.
module vector_element_sequencer #(
    parameter int VLEN = 128
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 vm,
    input  logic [4:0]           vd,
    input  logic [4:0]           vs1,
    input  logic [4:0]           vs2,
    input  logic [VLEN*32-1:0]   v_regs,
    input  logic [VLEN-1:0]      mask_registers,
    input  logic [31:0]          vl,
    input  logic [31:0]          vstart,
    input  logic                 vill,
    input  logic [2:0]           vsew,
    input  logic [2:0]           vlmul,
    output logic [VLEN*32-1:0]   new_v_regs,
    output logic [31:0]          new_vstart,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);
    localparam int RFW = VLEN * 32;
    localparam int BW  = $clog2(RFW);
    localparam int IW  = $clog2(VLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        vm_q, vm_d;
    logic [4:0]  vd_q, vd_d;
    logic [4:0]  vs1_q, vs1_d;
    logic [4:0]  vs2_q, vs2_d;
    logic [1:0]  sew_q, sew_d;
    logic [31:0] idx_q, idx_d;
    logic        illegal_q, illegal_d;

    logic [31:0]   vlmax_s;
    logic          reject_s;
    logic          last_s;
    logic          active_s;
    logic [IW-1:0] idx_lo_s;
    logic [BW-1:0] base_a_s, base_b_s, base_d_s;
    logic [31:0]   a_s, b_s, r_s;

    // Bit offset of element i of register r for the given SEW code.
    function automatic logic [BW-1:0] elem_base(input logic [4:0] r, input logic [IW-1:0] i,
                                                input logic [1:0] sew_code);
        logic [BW-1:0] off;
        off = BW'(i) << ({1'b0, sew_code} + 3'd3);
        return (BW'(r) * BW'(VLEN)) + off;
    endfunction

    // Legality of the request presented on the start cycle.
    always_comb begin
        case (vsew)
            3'd0:    vlmax_s = 32'(VLEN / 8);
            3'd1:    vlmax_s = 32'(VLEN / 16);
            3'd2:    vlmax_s = 32'(VLEN / 32);
            default: vlmax_s = 32'd0;
        endcase
        reject_s = vill | (vsew > 3'd2) | (vlmul != 3'd0) | (op == 3'd7) | (vl > vlmax_s);
    end

    // Element datapath: operands are read live so vd may alias a source register.
    always_comb begin
        idx_lo_s = idx_q[IW-1:0];
        last_s   = (idx_q + 32'd1) >= vl;
        active_s = vm_q | mask_registers[idx_lo_s];
        base_a_s = elem_base(vs2_q, idx_lo_s, sew_q);
        base_b_s = elem_base(vs1_q, idx_lo_s, sew_q);
        base_d_s = elem_base(vd_q, idx_lo_s, sew_q);
        a_s = 32'd0;
        b_s = 32'd0;
        case (sew_q)
            2'd0: begin
                a_s = {24'd0, v_regs[base_a_s +: 8]};
                b_s = {24'd0, v_regs[base_b_s +: 8]};
            end
            2'd1: begin
                a_s = {16'd0, v_regs[base_a_s +: 16]};
                b_s = {16'd0, v_regs[base_b_s +: 16]};
            end
            default: begin
                a_s = v_regs[base_a_s +: 32];
                b_s = v_regs[base_b_s +: 32];
            end
        endcase
        case (op_q)
            3'd0:    r_s = a_s + b_s;
            3'd1:    r_s = a_s - b_s;
            3'd2:    r_s = a_s & b_s;
            3'd3:    r_s = a_s | b_s;
            3'd4:    r_s = a_s ^ b_s;
            3'd5:    r_s = (a_s < b_s) ? a_s : b_s;
            3'd6:    r_s = (a_s > b_s) ? a_s : b_s;
            default: r_s = 32'd0;
        endcase
    end

    // Next-state and latch logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        vm_d      = vm_q;
        vd_d      = vd_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        sew_d     = sew_q;
        idx_d     = idx_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reject_s) begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                    end else if (vstart >= vl) begin
                        state_d   = S_DONE;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = S_RUN;
                        illegal_d = 1'b0;
                        op_d      = op;
                        vm_d      = vm;
                        vd_d      = vd;
                        vs1_d     = vs1;
                        vs2_d     = vs2;
                        sew_d     = vsew[1:0];
                        idx_d     = vstart;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                idx_d = idx_q + 32'd1;
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                illegal_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: pass-through everywhere except an active element in RUN.
    always_comb begin
        new_v_regs = v_regs;
        new_vstart = vstart;
        if (state_q == S_RUN) begin
            if (active_s) begin
                case (sew_q)
                    2'd0:    new_v_regs[base_d_s +: 8]  = r_s[7:0];
                    2'd1:    new_v_regs[base_d_s +: 16] = r_s[15:0];
                    default: new_v_regs[base_d_s +: 32] = r_s;
                endcase
            end else begin
                new_v_regs = v_regs;
            end
            new_vstart = last_s ? 32'd0 : (idx_q + 32'd1);
        end else begin
            new_v_regs = v_regs;
            new_vstart = vstart;
        end
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        illegal = (state_q == S_DONE) & illegal_q;
    end

    // State and latched-operation registers.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            vm_q      <= 1'b0;
            vd_q      <= 5'd0;
            vs1_q     <= 5'd0;
            vs2_q     <= 5'd0;
            sew_q     <= 2'd0;
            idx_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            vm_q      <= vm_d;
            vd_q      <= vd_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            sew_q     <= sew_d;
            idx_q     <= idx_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Scoreboard bench: a register-file model closes the loop around the sequencer,
// and an element-level reference model predicts each op's outcome.
module tb_vector_element_sequencer;
    localparam int VLEN = 128;
    localparam int RFW  = VLEN * 32;

    typedef struct {
        logic [RFW-1:0] regs;
        logic [31:0]    vst;
        logic           ill;
        int             lat;
        int             cyc;
    } exp_t;

    logic SYS_clk = 1'b0;
    logic SYS_reset_n;
    logic start;
    logic [2:0] op;
    logic vm;
    logic [4:0] vd, vs1, vs2;
    logic [VLEN-1:0] mask_registers;
    logic [31:0] vl;
    logic vill;
    logic [2:0] vsew, vlmul;
    logic [RFW-1:0] new_v_regs;
    logic [31:0] new_vstart;
    logic busy, done, illegal;

    logic [RFW-1:0] rf_q;
    logic [31:0]    vst_q;
    logic           load_en;
    logic [RFW-1:0] load_regs;
    logic [31:0]    load_vst;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    exp_t exp_q[$];
    logic [31:0] vs_q[$];

    vector_element_sequencer #(.VLEN(VLEN)) dut (
        .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n), .start(start), .op(op), .vm(vm),
        .vd(vd), .vs1(vs1), .vs2(vs2), .v_regs(rf_q), .mask_registers(mask_registers),
        .vl(vl), .vstart(vst_q), .vill(vill), .vsew(vsew), .vlmul(vlmul),
        .new_v_regs(new_v_regs), .new_vstart(new_vstart), .busy(busy), .done(done),
        .illegal(illegal)
    );

    always #5 SYS_clk = ~SYS_clk;

    always @(posedge SYS_clk) cyc <= cyc + 1;

    // Register file: captures the sequencer's next-state every clock unless preloaded.
    always @(posedge SYS_clk) begin
        if (load_en) begin
            rf_q  <= load_regs;
            vst_q <= load_vst;
        end else begin
            rf_q  <= new_v_regs;
            vst_q <= new_vstart;
        end
    end

    function automatic logic [31:0] sew_mask(input int sew);
        return (sew == 32) ? 32'hFFFF_FFFF : ((32'd1 << sew) - 32'd1);
    endfunction

    function automatic logic [31:0] get_el(input logic [RFW-1:0] rf, input int r, input int i, input int sew);
        logic [RFW-1:0] t;
        t = rf >> (r * VLEN + i * sew);
        return t[31:0] & sew_mask(sew);
    endfunction

    function automatic logic [RFW-1:0] put_el(input logic [RFW-1:0] rf, input int r, input int i,
                                              input int sew, input logic [31:0] v);
        logic [RFW-1:0] m, d;
        m = {{(RFW-32){1'b0}}, sew_mask(sew)} << (r * VLEN + i * sew);
        d = {{(RFW-32){1'b0}}, v & sew_mask(sew)} << (r * VLEN + i * sew);
        return (rf & ~m) | d;
    endfunction

    function automatic exp_t model(input logic [2:0] f_op, input logic f_vm, input logic [4:0] f_vd,
                                   input logic [4:0] f_vs1, input logic [4:0] f_vs2,
                                   input logic [VLEN-1:0] f_mask, input logic [31:0] f_vl,
                                   input logic [31:0] f_vst, input logic f_vill,
                                   input logic [2:0] f_vsew, input logic [2:0] f_vlmul,
                                   input logic [RFW-1:0] rin);
        exp_t e;
        int sew;
        logic [31:0] a, b, r;
        sew = (f_vsew <= 3'd2) ? (8 << f_vsew) : 8;
        e.ill = f_vill || (f_vsew > 3'd2) || (f_vlmul != 3'd0) || (f_op == 3'd7) || (f_vl > 32'(VLEN / sew));
        e.regs = rin;
        e.vst = f_vst;
        e.lat = 1;
        e.cyc = 0;
        if (!e.ill && f_vst < f_vl) begin
            for (int i = int'(f_vst); i < int'(f_vl); i++) begin
                a = get_el(rin, int'(f_vs2), i, sew);
                b = get_el(rin, int'(f_vs1), i, sew);
                case (f_op)
                    3'd0: r = a + b;
                    3'd1: r = a - b;
                    3'd2: r = a & b;
                    3'd3: r = a | b;
                    3'd4: r = a ^ b;
                    3'd5: r = (a < b) ? a : b;
                    3'd6: r = (a > b) ? a : b;
                    default: r = 32'd0;
                endcase
                if (f_vm || f_mask[i]) e.regs = put_el(e.regs, int'(f_vd), i, sew, r);
            end
            e.vst = 32'd0;
            e.lat = int'(f_vl - f_vst) + 1;
        end
        return e;
    endfunction

    function automatic logic [RFW-1:0] rand_rf();
        logic [RFW-1:0] r;
        for (int w = 0; w < RFW / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_w(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_rf(input string nm, input logic [RFW-1:0] act, input logic [RFW-1:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            for (int w = 0; w < RFW / 32; w++) begin
                if (act[w*32 +: 32] !== expv[w*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h", nm, w, act[w*32 +: 32], expv[w*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge SYS_clk);
            if (busy && !done) begin
                if (vs_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL vstart_step: unexpected RUN cycle, new_vstart %0d expected none", new_vstart);
                end else begin
                    chk32("vstart_step", new_vstart, vs_q.pop_front());
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL done_unexpected: got done=1 expected no pending op");
                end else begin
                    e = exp_q.pop_front();
                    chk32("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk32("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk32("final_vstart", vst_q, e.vst);
                    chk_rf("final_regs", rf_q, e.regs);
                    chk32("stream_left", 32'(vs_q.size()), 32'd0);
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] t_op, input logic t_vm, input logic [4:0] t_vd,
                         input logic [4:0] t_vs1, input logic [4:0] t_vs2, input logic [VLEN-1:0] t_mask,
                         input logic [31:0] t_vl, input logic [31:0] t_vst, input logic t_vill,
                         input logic [2:0] t_vsew, input logic [2:0] t_vlmul, input logic [RFW-1:0] t_rf);
        exp_t e;
        @(negedge SYS_clk);
        load_en = 1'b1;
        load_regs = t_rf;
        load_vst = t_vst;
        @(negedge SYS_clk);
        load_en = 1'b0;
        op = t_op; vm = t_vm; vd = t_vd; vs1 = t_vs1; vs2 = t_vs2;
        mask_registers = t_mask; vl = t_vl; vill = t_vill; vsew = t_vsew; vlmul = t_vlmul;
        start = 1'b1;
        e = model(t_op, t_vm, t_vd, t_vs1, t_vs2, t_mask, t_vl, t_vst, t_vill, t_vsew, t_vlmul, t_rf);
        e.cyc = cyc + e.lat;
        exp_q.push_back(e);
        if (!e.ill && t_vst < t_vl) begin
            for (int i = int'(t_vst); i < int'(t_vl); i++)
                vs_q.push_back((i + 1 == int'(t_vl)) ? 32'd0 : 32'(i + 1));
        end
        @(negedge SYS_clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge SYS_clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done within 100 cycles expected done");
            exp_q.delete();
            vs_q.delete();
        end
    endtask

    initial begin
        logic [RFW-1:0] rf;
        logic [VLEN-1:0] old;
        logic [VLEN-1:0] rmask;
        logic [2:0] r_vsew, r_vlmul;
        int vlmax;
        logic [31:0] r_vl, r_vst;
        exp_t part;

        SYS_reset_n = 1'b0;
        start = 1'b0; op = 3'd0; vm = 1'b1; vd = 5'd0; vs1 = 5'd0; vs2 = 5'd0;
        mask_registers = '0; vl = 32'd0; vill = 1'b0; vsew = 3'd0; vlmul = 3'd0;
        load_en = 1'b1;
        load_regs = rand_rf();
        load_vst = 32'd5;
        fork
            monitor();
        join_none
        repeat (3) @(negedge SYS_clk);
        chk32("rst_busy", {31'd0, busy}, 32'd0);
        chk32("rst_done", {31'd0, done}, 32'd0);
        chk32("rst_illegal", {31'd0, illegal}, 32'd0);
        chk32("rst_pass_vstart", new_vstart, 32'd5);
        chk_rf("rst_pass_regs", new_v_regs, load_regs);
        load_en = 1'b0;
        SYS_reset_n = 1'b1;

        // ADD SEW=8 with per-byte wraparound
        rf = rand_rf();
        rf[2*VLEN +: VLEN] = {16{8'hF0}};
        rf[1*VLEN +: VLEN] = {16{8'h20}};
        issue(3'd0, 1'b1, 5'd3, 5'd1, 5'd2, '0, 32'd16, 32'd0, 1'b0, 3'd0, 3'd0, rf);
        wait_done();
        chk_w("add_wrap_vd", rf_q[3*VLEN +: VLEN], {16{8'h10}});

        // SUB SEW=32, tail undisturbed
        rf = rand_rf();
        rf[2*VLEN +: VLEN] = {4{32'd5}};
        rf[1*VLEN +: VLEN] = {4{32'd7}};
        old = rf[9*VLEN +: VLEN];
        issue(3'd1, 1'b1, 5'd9, 5'd1, 5'd2, '0, 32'd2, 32'd0, 1'b0, 3'd2, 3'd0, rf);
        wait_done();
        chk_w("sub_tail_vd", rf_q[9*VLEN +: VLEN], {old[127:64], 32'hFFFF_FFFE, 32'hFFFF_FFFE});

        // MAXU SEW=16 masked by 0x00AA
        issue(3'd6, 1'b0, 5'd10, 5'd11, 5'd12, 128'h00AA, 32'd8, 32'd0, 1'b0, 3'd1, 3'd0, rand_rf());
        wait_done();

        // Illegal requests
        issue(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd4, 32'd0, 1'b0, 3'd3, 3'd0, rand_rf());
        wait_done();
        issue(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd4, 32'd0, 1'b0, 3'd0, 3'd1, rand_rf());
        wait_done();
        issue(3'd7, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd4, 32'd0, 1'b0, 3'd0, 3'd0, rand_rf());
        wait_done();
        issue(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd4, 32'd0, 1'b1, 3'd0, 3'd0, rand_rf());
        wait_done();
        issue(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd5, 32'd0, 1'b0, 3'd2, 3'd0, rand_rf());
        wait_done();

        // vstart == vl: legal, nothing to do
        issue(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, '0, 32'd4, 32'd4, 1'b0, 3'd0, 3'd0, rand_rf());
        wait_done();

        // Reset during element 3 of an XOR, with a start injected while busy
        rf = rand_rf();
        issue(3'd4, 1'b1, 5'd4, 5'd5, 5'd6, '0, 32'd8, 32'd0, 1'b0, 3'd1, 3'd0, rf);
        @(negedge SYS_clk);
        op = 3'd0;
        vd = 5'd7;
        start = 1'b1;
        @(negedge SYS_clk);
        start = 1'b0;
        @(posedge SYS_clk);
        #1;
        SYS_reset_n = 1'b0;
        #1;
        chk32("abort_busy", {31'd0, busy}, 32'd0);
        part = model(3'd4, 1'b1, 5'd4, 5'd5, 5'd6, '0, 32'd3, 32'd0, 1'b0, 3'd1, 3'd0, rf);
        chk_rf("abort_regs", rf_q, part.regs);
        chk32("abort_vstart", vst_q, 32'd3);
        chk32("abort_unprocessed", 32'(vs_q.size()), 32'd5);
        chk_rf("abort_pass_regs", new_v_regs, rf_q);
        exp_q.delete();
        vs_q.delete();
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
        repeat (2) @(negedge SYS_clk);

        // Randomized ops
        for (int n = 0; n < 60; n++) begin
            r_vsew = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_vlmul = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            vlmax = VLEN / (8 << ((r_vsew > 3'd2) ? 3'd2 : r_vsew));
            r_vl = 32'($urandom_range(0, vlmax + 1));
            r_vst = 32'($urandom_range(0, int'(r_vl)));
            rmask = {$urandom(), $urandom(), $urandom(), $urandom()};
            issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rmask, r_vl, r_vst,
                  ($urandom_range(0, 19) == 0), r_vsew, r_vlmul, rand_rf());
            wait_done();
        end

        repeat (3) @(negedge SYS_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
